// File: rtl/m3_pkg.sv
// Shared types and helpers for the m3 motor power/speed ramp.
package m3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP      = 3'd1,
        ST_RUN       = 3'd2,
        ST_REV_DOWN  = 3'd3,
        ST_STOP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Operands are zero-extended to 32 bits by the caller; any setpoint width up to 31 bits fits.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] step,
                                            input logic [31:0] hi);
        return (a + step > hi) ? hi : a + step;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] step,
                                            input logic [31:0] lo);
        return (a < lo + step) ? lo : a - step;
    endfunction

endpackage

// File: rtl/m3_ramp_step.sv
// One ramped channel: on each tick, move cur toward goal by STEP and land exactly on goal.
module m3_ramp_step #(
    parameter int           W    = 16,
    parameter logic [W-1:0] STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] goal,
    output logic [W-1:0] cur
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
        end else if (ld) begin
            cur <= ld_val;
        end else if (tick) begin
            if (cur < goal)
                cur <= (goal - cur <= STEP) ? goal : cur + STEP;
            else if (cur > goal)
                cur <= (cur - goal <= STEP) ? goal : cur - STEP;
        end
    end

endmodule

// File: rtl/m3_power_speed_ramp.sv
// Operator requests -> ramped frequency/power setpoints and direction for the 3-phase generator.
module m3_power_speed_ramp
    import m3_pkg::*;
#(
    parameter int                FREQ_W    = 16,
    parameter int                PWR_W     = 10,
    parameter logic [FREQ_W-1:0] FREQ_MIN  = 16'd50,
    parameter logic [FREQ_W-1:0] FREQ_MAX  = 16'd4000,
    parameter logic [FREQ_W-1:0] FREQ_STEP = 16'd10,
    parameter logic [PWR_W-1:0]  PWR_MIN   = 10'd64,
    parameter logic [PWR_W-1:0]  PWR_MAX   = 10'd1000,
    parameter logic [PWR_W-1:0]  PWR_STEP  = 10'd8,
    parameter int                RAMP_DIV  = 1000
) (
    input  logic              clkI,
    input  logic              rstI,
    input  logic              m3startI,
    input  logic              m3forceStopI,
    input  logic              m3invRotateI,
    input  logic              m3freqINCi,
    input  logic              m3freqDECi,
    input  logic              m3powerINCi,
    input  logic              m3powerDECi,
    output logic [FREQ_W-1:0] freqO,
    output logic [PWR_W-1:0]  powerO,
    output logic              dirO,
    output logic              runO,
    output logic [2:0]        stateO
);

    localparam int            CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);

    state_t            state, state_nxt;
    logic [4:0]        req_q, req_d, req_edge;
    logic              e_rev, e_pi, e_pd, e_fi, e_fd;
    logic [FREQ_W-1:0] tgt_f, tgt_f_n, goal_f, ld_f;
    logic [PWR_W-1:0]  tgt_p, tgt_p_n, goal_p, ld_p;
    logic              tgt_chg, at_goal, at_min;
    logic [CW-1:0]     cnt;
    logic              tick, ramp_en, ld, dir_tgl;

    // Two-stage capture so a request acts one clock after its rising edge.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            req_q <= '0;
            req_d <= '0;
        end else begin
            req_q <= {m3invRotateI, m3powerINCi, m3powerDECi, m3freqINCi, m3freqDECi};
            req_d <= req_q;
        end
    end
    assign req_edge = req_q & ~req_d;
    assign {e_rev, e_pi, e_pd, e_fi, e_fd} = req_edge;

    // Force-stop wins over target edges arriving in the same cycle.
    always_comb begin
        tgt_f_n = tgt_f;
        tgt_p_n = tgt_p;
        if (!m3forceStopI) begin
            if (e_fi && !e_fd)
                tgt_f_n = FREQ_W'(sat_add(32'(tgt_f), 32'(FREQ_STEP), 32'(FREQ_MAX)));
            else if (e_fd && !e_fi)
                tgt_f_n = FREQ_W'(sat_sub(32'(tgt_f), 32'(FREQ_STEP), 32'(FREQ_MIN)));
            if (e_pi && !e_pd)
                tgt_p_n = PWR_W'(sat_add(32'(tgt_p), 32'(PWR_STEP), 32'(PWR_MAX)));
            else if (e_pd && !e_pi)
                tgt_p_n = PWR_W'(sat_sub(32'(tgt_p), 32'(PWR_STEP), 32'(PWR_MIN)));
        end
    end
    assign tgt_chg = (tgt_f_n != tgt_f) || (tgt_p_n != tgt_p);

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            tgt_f <= FREQ_MIN;
            tgt_p <= PWR_MIN;
        end else begin
            tgt_f <= tgt_f_n;
            tgt_p <= tgt_p_n;
        end
    end

    assign at_goal = (freqO == tgt_f) && (powerO == tgt_p);
    assign at_min  = (freqO == FREQ_MIN) && (powerO == PWR_MIN);

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (m3forceStopI) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE:      if (m3startI) state_nxt = ST_RAMP;
                ST_RAMP: begin
                    if (!m3startI)                 state_nxt = ST_STOP_DOWN;
                    else if (e_rev)                state_nxt = ST_REV_DOWN;
                    else if (at_goal && !tgt_chg)  state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!m3startI)    state_nxt = ST_STOP_DOWN;
                    else if (e_rev)   state_nxt = ST_REV_DOWN;
                    else if (tgt_chg) state_nxt = ST_RAMP;
                end
                ST_REV_DOWN: begin
                    if (!m3startI)   state_nxt = ST_STOP_DOWN;
                    else if (at_min) state_nxt = ST_RAMP;
                end
                ST_STOP_DOWN: begin
                    if (m3startI)    state_nxt = ST_RAMP;
                    else if (at_min) state_nxt = ST_IDLE;
                end
                ST_FAULT:     if (!m3startI) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ramp_en = state inside {ST_RAMP, ST_RUN, ST_REV_DOWN, ST_STOP_DOWN};
        goal_f  = tgt_f;
        goal_p  = tgt_p;
        if (state inside {ST_REV_DOWN, ST_STOP_DOWN}) begin
            goal_f = FREQ_MIN;
            goal_p = PWR_MIN;
        end
        ld   = 1'b0;
        ld_f = '0;
        ld_p = '0;
        if (state_nxt == ST_FAULT || (state_nxt == ST_IDLE && state != ST_IDLE)) begin
            ld = 1'b1;
        end else if (state == ST_IDLE && state_nxt == ST_RAMP) begin
            ld   = 1'b1;
            ld_f = FREQ_MIN;
            ld_p = PWR_MIN;
        end
        dir_tgl = (state == ST_IDLE && e_rev && !m3forceStopI) ||
                  (state == ST_REV_DOWN && state_nxt == ST_RAMP);
    end

    // Tick phase restarts on every state change so each phase gets full ramp periods.
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI)                    cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else if (cnt == CNT_LAST)    cnt <= '0;
        else                         cnt <= cnt + 1'b1;
    end
    assign tick = (cnt == CNT_LAST) && ramp_en;

    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI)         dirO <= 1'b0;
        else if (dir_tgl) dirO <= ~dirO;
    end

    m3_ramp_step #(.W(FREQ_W), .STEP(FREQ_STEP)) u_freq (
        .clk(clkI), .rst(rstI), .tick(tick), .ld(ld), .ld_val(ld_f), .goal(goal_f), .cur(freqO)
    );

    m3_ramp_step #(.W(PWR_W), .STEP(PWR_STEP)) u_pwr (
        .clk(clkI), .rst(rstI), .tick(tick), .ld(ld), .ld_val(ld_p), .goal(goal_p), .cur(powerO)
    );

    assign runO   = ramp_en;
    assign stateO = state;

endmodule

// File: tb/tb_m3_power_speed_ramp.sv
// Directed bench for m3_power_speed_ramp with default parameters.
module tb_m3_power_speed_ramp;

    localparam logic [4:0] B_REV = 5'b10000;
    localparam logic [4:0] B_PI  = 5'b01000;
    localparam logic [4:0] B_PD  = 5'b00100;
    localparam logic [4:0] B_FI  = 5'b00010;
    localparam logic [4:0] B_FD  = 5'b00001;

    logic        clk, rst, start, force_stop;
    logic [4:0]  btn;
    logic [15:0] freq;
    logic [9:0]  power;
    logic        dir, run;
    logic [2:0]  state;
    int          n_tests, n_fail, cyc;

    m3_power_speed_ramp dut (
        .clkI(clk), .rstI(rst), .m3startI(start), .m3forceStopI(force_stop),
        .m3invRotateI(btn[4]), .m3powerINCi(btn[3]), .m3powerDECi(btn[2]),
        .m3freqINCi(btn[1]), .m3freqDECi(btn[0]),
        .freqO(freq), .powerO(power), .dirO(dir), .runO(run), .stateO(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [4:0] m);
        btn = m;
        step(1);
        btn = '0;
        step(1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; force_stop = 1'b0; btn = '0;
        step(2);
        chk("rst_freq", freq, 0);
        chk("rst_power", power, 0);
        chk("rst_dir", dir, 0);
        chk("rst_run", run, 0);
        chk("rst_state", state, 0);
        chk("rst_tgt_f", dut.tgt_f, 50);
        chk("rst_tgt_p", dut.tgt_p, 64);
        rst = 1'b0;
        step(1);

        // start -> RAMP at minimum, then 5 freq steps up to 100
        start = 1'b1;
        step(1);
        chk("start_state", state, 1);
        chk("start_freq", freq, 50);
        chk("start_power", power, 64);
        chk("start_run", run, 1);
        repeat (5) pulse(B_FI);
        chk("inc_tgt_f", dut.tgt_f, 100);
        cyc = 0;
        while (!(state == 3'd2 && freq == 16'd100) && cyc < 6000) begin step(1); cyc++; end
        chk("ramp_up_freq", freq, 100);
        chk("ramp_up_state", state, 2);
        chk("ramp_up_time", (cyc >= 4900 && cyc <= 5100), 1);

        // reversal from RUN
        pulse(B_REV);
        chk("rev_state", state, 3);
        chk("rev_freq_hold", freq, 100);
        cyc = 0;
        while (dir !== 1'b1 && cyc < 6000) begin step(1); cyc++; end
        chk("rev_dir", dir, 1);
        chk("rev_state_ramp", state, 1);
        chk("rev_freq_min", freq, 50);
        cyc = 0;
        while (state !== 3'd2 && cyc < 6000) begin step(1); cyc++; end
        chk("rev_rerun_state", state, 2);
        chk("rev_rerun_freq", freq, 100);
        chk("rev_rerun_dir", dir, 1);

        // stop from RAMP
        pulse(B_FI);
        chk("stop_pre_state", state, 1);
        start = 1'b0;
        step(1);
        chk("stop_state", state, 4);
        chk("stop_run", run, 1);
        cyc = 0;
        while (state !== 3'd0 && cyc < 6000) begin step(1); cyc++; end
        chk("stop_idle", state, 0);
        chk("stop_freq", freq, 0);
        chk("stop_power", power, 0);
        chk("stop_run0", run, 0);
        chk("stop_dir_kept", dir, 1);

        // reversal in IDLE toggles direction directly
        pulse(B_REV);
        chk("idle_rev_dir", dir, 0);
        chk("idle_rev_state", state, 0);

        // target saturation and simultaneous inc/dec
        repeat (400) pulse(B_FI);
        chk("sat_tgt_f", dut.tgt_f, 4000);
        pulse(B_FI | B_FD);
        chk("incdec_tgt_f", dut.tgt_f, 4000);
        pulse(B_FD);
        chk("dec_tgt_f", dut.tgt_f, 3990);
        pulse(B_PD);
        chk("sat_tgt_p", dut.tgt_p, 64);
        pulse(B_PI);
        chk("inc_tgt_p", dut.tgt_p, 72);

        // force stop mid-ramp, coincident with an inc edge
        start = 1'b1;
        step(1);
        chk("fs_start_state", state, 1);
        step(2500);
        chk("fs_mid_freq", freq, 70);
        chk("fs_mid_power", power, 72);
        btn = B_FI;
        step(1);
        force_stop = 1'b1;
        step(1);
        btn = '0;
        chk("fs_state", state, 5);
        chk("fs_freq", freq, 0);
        chk("fs_power", power, 0);
        chk("fs_run", run, 0);
        force_stop = 1'b0;
        step(3);
        chk("fs_hold_fault", state, 5);
        start = 1'b0;
        step(1);
        chk("fs_rearm_idle", state, 0);

        // async reset in REV_DOWN
        pulse(B_REV);
        chk("ar_dir_set", dir, 1);
        start = 1'b1;
        step(1);
        step(2500);
        pulse(B_REV);
        chk("ar_state_rev", state, 3);
        chk("ar_freq_rev", freq, 70);
        #3 rst = 1'b1;
        #1;
        chk("ar_freq", freq, 0);
        chk("ar_power", power, 0);
        chk("ar_dir", dir, 0);
        chk("ar_run", run, 0);
        chk("ar_state", state, 0);
        start = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
